// File: rtl/data_exec_stage_md.sv
// RV execute stage: forward/ALU-source muxes, ALU and target adder (combinational, zero latency), plus an
// iterative M unit (XLEN+2 cycles, 2 for div-by-zero/overflow); o_stall holds the pipe while an M-op is in flight.
module data_exec_stage_md #(
  parameter  int XLEN    = 32,
  parameter  int NUM_FWD = 3,
  localparam int FSW     = $clog2(NUM_FWD + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic                    i_flush,
  input  logic [XLEN-1:0]         i_rd1,
  input  logic [XLEN-1:0]         i_rd2,
  input  logic [XLEN-1:0]         i_immext,
  input  logic [XLEN-1:0]         i_pc,
  input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
  input  logic [FSW-1:0]          i_fwd_sel_a,
  input  logic [FSW-1:0]          i_fwd_sel_b,
  input  logic [3:0]              i_alu_control,
  input  logic                    i_src_a,
  input  logic                    i_src_b,
  input  logic                    i_pc_adder_src,
  input  logic                    i_md_en,
  input  logic [2:0]              i_md_op,
  output logic [XLEN-1:0]         o_result,
  output logic [XLEN-1:0]         o_memory_data,
  output logic [3:0]              o_alu_flags,
  output logic [XLEN-1:0]         o_pc_adder_result,
  output logic                    o_stall,
  output logic                    o_md_busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, b_eff, sum, alu_res;
  logic            carry, ovf, is_sub;
  logic [SW-1:0]   shamt;

  // sel values above NUM_FWD fall back to the regfile
  always_comb begin
    fwd_a = i_rd1;
    fwd_b = i_rd2;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (i_fwd_sel_a == FSW'(k)) fwd_a = i_fwd_data[(k-1)*XLEN +: XLEN];
      if (i_fwd_sel_b == FSW'(k)) fwd_b = i_fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

  assign src_a  = i_src_a ? i_pc : fwd_a;
  assign src_b  = i_src_b ? i_immext : fwd_b;
  assign is_sub = (i_alu_control == ALU_SUB) || (i_alu_control == ALU_SLT) ||
                  (i_alu_control == ALU_SLTU);
  assign b_eff  = is_sub ? ~src_b : src_b;
  assign {carry, sum} = {1'b0, src_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
  assign ovf    = (src_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
  assign shamt  = src_b[SW-1:0];

  always_comb begin
    case (i_alu_control)
      ALU_ADD, ALU_SUB: alu_res = sum;
      ALU_AND:          alu_res = src_a & src_b;
      ALU_OR:           alu_res = src_a | src_b;
      ALU_XOR:          alu_res = src_a ^ src_b;
      ALU_SLT:          alu_res = XLEN'(sum[XLEN-1] ^ ovf);
      ALU_SLTU:         alu_res = XLEN'(!carry);
      ALU_SLL:          alu_res = src_a << shamt;
      ALU_SRL:          alu_res = src_a >> shamt;
      ALU_SRA:          alu_res = $signed(src_a) >>> shamt;
      default:          alu_res = src_b;
    endcase
  end

  assign o_alu_flags       = {alu_res[XLEN-1], alu_res == '0, carry, ovf};
  assign o_memory_data     = fwd_b;
  assign o_pc_adder_result = (i_pc_adder_src ? fwd_a : i_pc) + i_immext;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] m_q, hi_q, lo_q, md_res;
  logic [2:0]      op_q;
  logic            neg_q_q, neg_r_q;

  logic            accept, sgn_a, sgn_b, a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, mul_hi_d, mul_lo_d, div_hi_d, div_lo_d;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ge;
  logic [2*XLEN-1:0] prod, prod_s;

  assign accept   = (state_q == S_IDLE) && i_valid && i_md_en && !i_flush;
  assign sgn_a    = (i_md_op != 3'b011) && (i_md_op != 3'b101) && (i_md_op != 3'b111);
  assign sgn_b    = sgn_a && (i_md_op != 3'b010);
  assign a_neg    = sgn_a && fwd_a[XLEN-1];
  assign b_neg    = sgn_b && fwd_b[XLEN-1];
  assign a_mag    = a_neg ? -fwd_a : fwd_a;
  assign b_mag    = b_neg ? -fwd_b : fwd_b;
  assign is_div   = i_md_op[2];
  assign div_zero = is_div && (fwd_b == '0);
  assign div_ovf  = is_div && !i_md_op[0] && (fwd_a == MIN_VAL) && (fwd_b == '1);

  // Multiply: lo_q holds the multiplier and shifts out as product bits shift in
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign mul_hi_d = mul_sum[XLEN:1];
  assign mul_lo_d = {mul_sum[0], lo_q[XLEN-1:1]};

  // Divide: restoring; hi_q is the partial remainder, lo_q dividend bits become quotient bits
  assign div_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, m_q};
  assign div_ge   = !div_diff[XLEN];
  assign div_hi_d = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
  assign div_lo_d = {lo_q[XLEN-2:0], div_ge};

  assign prod   = {hi_q, lo_q};
  assign prod_s = neg_q_q ? -prod : prod;

  always_comb begin
    case (op_q)
      3'b000:         md_res = prod_s[XLEN-1:0];
      3'b100, 3'b101: md_res = neg_q_q ? -lo_q : lo_q;
      3'b110, 3'b111: md_res = neg_r_q ? -hi_q : hi_q;
      default:        md_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q    <= i_md_op;
          cnt_q   <= CW'(XLEN);
          hi_q    <= '0;
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          if (div_zero) begin
            state_q <= S_DONE;
            lo_q    <= '1;
            hi_q    <= fwd_a;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
          end else if (div_ovf) begin
            state_q <= S_DONE;
            lo_q    <= MIN_VAL;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
          end else begin
            state_q <= S_BUSY;
            m_q     <= is_div ? b_mag : a_mag;
            lo_q    <= is_div ? a_mag : b_mag;
          end
        end
        S_BUSY: if (i_flush) begin
          state_q <= S_IDLE;
        end else begin
          hi_q  <= op_q[2] ? div_hi_d : mul_hi_d;
          lo_q  <= op_q[2] ? div_lo_d : mul_lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_stall   = i_rst_n && !i_flush && (accept || (state_q == S_BUSY));
  assign o_md_busy = (state_q == S_BUSY);
  assign o_result  = (state_q == S_DONE) ? md_res : alu_res;
endmodule

// File: tb/tb_data_exec_stage_md.sv
// Bench for data_exec_stage_md: ALU/forward vector table, then M-ops checked through an expected-result queue.
module tb_data_exec_stage_md;
  localparam int XLEN = 32;
  localparam int NUM_FWD = 2;
  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, flush = 1'b0;
  logic [31:0] rd1 = '0, rd2 = '0, immext = '0, pc = '0;
  logic [63:0] fwd_data = '0;
  logic [1:0]  sel_a = '0, sel_b = '0;
  logic [3:0]  alu_ctl = '0;
  logic        src_a = 1'b0, src_b = 1'b0, pc_src = 1'b0, md_en = 1'b0;
  logic [2:0]  md_op = '0;
  logic [31:0] result, mem_data, pc_add;
  logic [3:0]  flags;
  logic        stall, md_busy;

  always #5 clk = ~clk;

  data_exec_stage_md #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_flush(flush),
    .i_rd1(rd1), .i_rd2(rd2), .i_immext(immext), .i_pc(pc), .i_fwd_data(fwd_data),
    .i_fwd_sel_a(sel_a), .i_fwd_sel_b(sel_b), .i_alu_control(alu_ctl),
    .i_src_a(src_a), .i_src_b(src_b), .i_pc_adder_src(pc_src),
    .i_md_en(md_en), .i_md_op(md_op),
    .o_result(result), .o_memory_data(mem_data), .o_alu_flags(flags),
    .o_pc_adder_result(pc_add), .o_stall(stall), .o_md_busy(md_busy)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    logic [31:0] r;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == MIN_VAL) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: if (b == 0) r = '1; else if (ovf) r = MIN_VAL; else r = $signed(a) / $signed(b);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a; else if (ovf) r = '0; else r = $signed(a) % $signed(b);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Drives one M-op into IDLE, then watches stall/busy until the DONE cycle and pops the expected result.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int  stall_n, busy_n;
    bit  got, special;
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b1; md_op = op; rd1 = a; rd2 = b;
    sel_a = 2'd0; sel_b = 2'd0; flush = 1'b0;
    exp_q.push_back(md_model(op, a, b));
    special = op[2] && ((b == 32'h0) || (!op[0] && a == MIN_VAL && b == 32'hFFFF_FFFF));
    stall_n = 0; busy_n = 0; got = 1'b0;
    for (int c = 0; c < XLEN + 8 && !got; c++) begin
      @(negedge clk);
      if (md_busy) busy_n++;
      if (stall) begin
        stall_n++;
        if (poke && c == 1) begin rd1 = ~a; rd2 = ~b; end
      end else begin
        got = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL md_result op=%0d: got 0x%08h but no result was expected", op, result);
        end else begin
          check($sformatf("md_result op=%0d a=%08h b=%08h", op, a, b), result, exp_q.pop_front());
        end
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL md_timeout op=%0d: stall still high after %0d cycles, required drop", op, XLEN + 8);
      void'(exp_q.pop_front());
    end
    check($sformatf("md_stall_cycles op=%0d", op), 32'(stall_n), special ? 32'd1 : 32'(XLEN + 1));
    check($sformatf("md_busy_cycles op=%0d", op), 32'(busy_n), special ? 32'd0 : 32'(XLEN));
  endtask

  typedef struct {
    logic [1:0]  sa, sb;
    logic [3:0]  ctl;
    logic        srca, srcb, pcs;
    logic [31:0] imm, res, mem, pca;
    logic        chkf;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{2'd2, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h1238, 32'h20, 32'h1004, 1'b1, 4'b0000};
    vecs[1]  = '{2'd3, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h104, 32'h20, 32'h1004, 1'b0, 4'b0000};
    vecs[2]  = '{2'd1, 2'd2, 4'd1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h7FFF_EE76, 32'h1234, 32'h8000_00AE, 1'b1, 4'b0011};
    vecs[3]  = '{2'd0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 32'h8000_00AA, 32'h1004, 1'b1, 4'b0100};
    vecs[4]  = '{2'd0, 2'd1, 4'd3, 1'b0, 1'b0, 1'b0, 32'h4, 32'h8000_01AA, 32'h8000_00AA, 32'h1004, 1'b0, 4'b0000};
    vecs[5]  = '{2'd2, 2'd1, 4'd4, 1'b0, 1'b0, 1'b0, 32'h4, 32'h8000_129E, 32'h8000_00AA, 32'h1004, 1'b0, 4'b0000};
    vecs[6]  = '{2'd1, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 32'h4, 32'h1, 32'h20, 32'h1004, 1'b0, 4'b0000};
    vecs[7]  = '{2'd1, 2'd0, 4'd6, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 32'h20, 32'h1004, 1'b0, 4'b0000};
    vecs[8]  = '{2'd0, 2'd0, 4'd7, 1'b0, 1'b1, 1'b0, 32'h4, 32'h1000, 32'h20, 32'h1004, 1'b0, 4'b0000};
    vecs[9]  = '{2'd1, 2'd0, 4'd8, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0800_000A, 32'h20, 32'h8000_00AE, 1'b0, 4'b0000};
    vecs[10] = '{2'd1, 2'd0, 4'd9, 1'b0, 1'b1, 1'b0, 32'h4, 32'hF800_000A, 32'h20, 32'h1004, 1'b0, 4'b0000};
    vecs[11] = '{2'd0, 2'd0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h1234_5000, 32'h1234_5000, 32'h20, 32'h1234_6000, 1'b0, 4'b0000};
    vecs[12] = '{2'd0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h1004, 32'h20, 32'h104, 1'b0, 4'b0000};
    vecs[13] = '{2'd0, 2'd0, 4'd1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h20, 32'h1100, 1'b1, 4'b0110};
    vecs[14] = '{2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF00, 32'h120, 32'h20, 32'h0, 1'b1, 4'b0000};

    // Reset: an M-op presented during reset must not stall
    valid = 1'b1; md_en = 1'b1; md_op = 3'd0;
    #12;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    valid = 1'b0; md_en = 1'b0; rst_n = 1'b1;

    // Combinational ALU / forwarding table
    rd1 = 32'h100; rd2 = 32'h20; pc = 32'h1000;
    fwd_data = {32'h0000_1234, 32'h8000_00AA};
    valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      sel_a = vecs[i].sa; sel_b = vecs[i].sb; alu_ctl = vecs[i].ctl;
      src_a = vecs[i].srca; src_b = vecs[i].srcb; pc_src = vecs[i].pcs; immext = vecs[i].imm;
      #2;
      check($sformatf("alu_result[%0d]", i), result, vecs[i].res);
      check($sformatf("mem_data[%0d]", i), mem_data, vecs[i].mem);
      check($sformatf("pc_adder[%0d]", i), pc_add, vecs[i].pca);
      check($sformatf("alu_stall[%0d]", i), 32'(stall), 32'd0);
      if (vecs[i].chkf) check($sformatf("alu_flags[%0d]", i), 32'(flags), 32'(vecs[i].flg));
    end
    src_a = 1'b0; src_b = 1'b0; pc_src = 1'b0; alu_ctl = 4'd0;

    // M-ops, back to back
    run_md(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_md(3'd4, 32'd100, 32'd0, 1'b0);
    run_md(3'd6, 32'd100, 32'd0, 1'b0);
    run_md(3'd5, 32'd100, 32'd0, 1'b0);
    run_md(3'd4, MIN_VAL, 32'hFFFF_FFFF, 1'b0);
    run_md(3'd6, MIN_VAL, 32'hFFFF_FFFF, 1'b0);
    run_md(3'd5, MIN_VAL, 32'd3, 1'b1);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_md(3'd7, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_md(3'd4, MIN_VAL, 32'd1, 1'b0);
    run_md(3'd0, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0; md_en = 1'b0;

    // Flush in the accept cycle
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b1; md_op = 3'd0; flush = 1'b1;
    #1;
    check("flush_accept_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("flush_accept_idle", 32'(md_busy), 32'd0);
    valid = 1'b0; md_en = 1'b0; flush = 1'b0;

    // Flush at BUSY cycle 10
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b1; md_op = 3'd0; rd1 = 32'd5; rd2 = 32'd6;
    repeat (10) begin @(posedge clk); #1; end
    check("busy_before_flush", 32'(md_busy), 32'd1);
    flush = 1'b1;
    #1;
    check("flush_stall_drop", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("flush_idle", 32'(md_busy), 32'd0);
    valid = 1'b0; md_en = 1'b0; flush = 1'b0;
    run_md(3'd0, 32'd9, 32'd11, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0; md_en = 1'b0;

    // Reset asserted at BUSY cycle 5
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b1; md_op = 3'd5; rd1 = 32'd1000; rd2 = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    check("busy_before_reset", 32'(md_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_stall", 32'(stall), 32'd0);
    check("reset_mid_busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    valid = 1'b0; md_en = 1'b0; rst_n = 1'b1;
    run_md(3'd5, 32'd1000, 32'd7, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0; md_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
